rst_seq_gen: RTL and testbench



---
 rtl/rst_seq_gen_pkg.sv | 22 ++
 rtl/rst_pulse_ch.sv | 44 ++++
 rtl/rst_seq_gen.sv | 147 ++++++++++++++
 tb/tb_rst_seq_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_gen_pkg.sv
// rst_seq_pkg: shared types and defaults for the reset sequencer.
// Holds the FSM state enum, default parameters and a width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } rst_seq_state_e;

  localparam int DEF_NUM_RST     = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_FILT   = 16;
  localparam int DEF_STAGE_DLY   = 8;
  localparam int DEF_SW_PULSE    = 4;

  // Counter width for a counter whose largest value is below v.
  function automatic int cw(int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rst_pulse_ch.sv
// rst_pulse_ch: per-channel software reset pulse counter.
// Ports: clk_i, rstn_i (sync, active-low), req_i request, en_i accept
//   requests, clr_i abort pulse, pulse_active_o high while counting.
module rst_pulse_ch
  import rst_seq_pkg::*;
#(
  parameter int SW_PULSE = DEF_SW_PULSE
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic req_i,
  input  logic en_i,
  input  logic clr_i,
  output logic pulse_active_o
);

  // Must hold SW_PULSE itself, not just SW_PULSE-1.
  localparam int CW = $clog2(SW_PULSE + 1);
  localparam logic [CW-1:0] LOAD = CW'(SW_PULSE);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (req_i && en_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_active_o = (cnt_q != '0);

endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: lock-qualified staggered release of NUM_RST resets.
// Ports: clk_i, rstn_i (sync, active-low), lock_i (async), testmode_i,
//   sw_rst_req_i per-channel pulse request; rstn_o channel resets,
//   ready_o all released, lock_lost_o sticky lock-drop flag.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST     = DEF_NUM_RST,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_FILT   = DEF_LOCK_FILT,
  parameter int STAGE_DLY   = DEF_STAGE_DLY,
  parameter int SW_PULSE    = DEF_SW_PULSE
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               lock_i,
  input  logic               testmode_i,
  input  logic [NUM_RST-1:0] sw_rst_req_i,
  output logic [NUM_RST-1:0] rstn_o,
  output logic               ready_o,
  output logic               lock_lost_o
);

  localparam int FW = cw(LOCK_FILT);
  localparam int DW = cw(STAGE_DLY);
  localparam int IW = cw(NUM_RST);
  localparam logic [FW-1:0] FLT_MAX = FW'(LOCK_FILT - 1);
  localparam logic [DW-1:0] DLY_MAX = DW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_RST - 1);
  localparam logic [NUM_RST-1:0] ONE = NUM_RST'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rst_seq_state_e         state_q, state_d;
  logic [FW-1:0]          flt_q, flt_d;
  logic [DW-1:0]          stg_q, stg_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_RST-1:0]     rel_q, rel_d;
  logic                   lost_q, lost_d;

  logic               lock_s;
  logic [IW-1:0]      idx_nxt;
  logic               pulse_en;
  logic               pulse_clr;
  logic [NUM_RST-1:0] pulse_act;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], lock_i};
    state_d   = state_q;
    flt_d     = flt_q;
    stg_d     = stg_q;
    idx_d     = idx_q;
    rel_d     = rel_q;
    lost_d    = lost_q;
    pulse_en  = 1'b0;
    pulse_clr = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!lock_s) begin
          flt_d = '0;
        end else if (flt_q == FLT_MAX) begin
          flt_d   = '0;
          stg_d   = '0;
          idx_d   = '0;
          rel_d   = ONE;
          state_d = (NUM_RST == 1) ? RUN : RELEASE;
        end else begin
          flt_d = flt_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          // Loss beats any release step or sw request this edge.
          state_d   = WAIT_LOCK;
          rel_d     = '0;
          stg_d     = '0;
          idx_d     = '0;
          lost_d    = 1'b1;
          pulse_clr = 1'b1;
        end else if (state_q == RUN) begin
          pulse_en = 1'b1;
        end else if (stg_q == DLY_MAX) begin
          stg_d = '0;
          idx_d = idx_nxt;
          rel_d = rel_q | (ONE << idx_nxt);
          if (idx_nxt == IDX_LAST) begin
            state_d = RUN;
          end
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q  <= '0;
      state_q <= WAIT_LOCK;
      flt_q   <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      flt_q   <= flt_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      lost_q  <= lost_d;
    end
  end

  for (genvar k = 0; k < NUM_RST; k++) begin : g_ch
    rst_pulse_ch #(
      .SW_PULSE(SW_PULSE)
    ) u_ch (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .req_i         (sw_rst_req_i[k]),
      .en_i          (pulse_en),
      .clr_i         (pulse_clr),
      .pulse_active_o(pulse_act[k])
    );
  end

  // Scan owns every reset directly from the pad in test mode.
  always_comb begin
    if (testmode_i) begin
      rstn_o  = {NUM_RST{rstn_i}};
      ready_o = rstn_i;
    end else begin
      rstn_o  = rel_q & ~pulse_act;
      ready_o = (state_q == RUN);
    end
  end

  assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: directed and random checks of rst_seq_gen
// against an edge-indexed behavioural model.
module tb_rst_seq_gen;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int LF = 16;
  localparam int SD = 8;
  localparam int SP = 4;

  logic         clk;
  logic         rstn;
  logic         lock;
  logic         tm;
  logic [N-1:0] sw;
  logic [N-1:0] rstn_o;
  logic         ready;
  logic         lost;

  logic [0:0]   sw1;
  logic [0:0]   rstn1_o;
  logic         ready1;
  logic         lost1;

  rst_seq_gen #(
    .NUM_RST(N), .SYNC_STAGES(SS), .LOCK_FILT(LF),
    .STAGE_DLY(SD), .SW_PULSE(SP)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .lock_i(lock),
    .testmode_i(tm), .sw_rst_req_i(sw),
    .rstn_o(rstn_o), .ready_o(ready), .lock_lost_o(lost)
  );

  rst_seq_gen #(
    .NUM_RST(1), .SYNC_STAGES(2), .LOCK_FILT(1),
    .STAGE_DLY(8), .SW_PULSE(4)
  ) dut1 (
    .clk_i(clk), .rstn_i(rstn), .lock_i(lock),
    .testmode_i(tm), .sw_rst_req_i(sw1),
    .rstn_o(rstn1_o), .ready_o(ready1), .lock_lost_o(lost1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int fails;

  // Model: edge counter, synchroniser history, consecutive-high run,
  // edge at which release began (-1 none), per-channel pulse end edge.
  int e;
  bit sq[$];
  int run;
  int rel_start;
  bit m_lost;
  int pend[N];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_rstn();
    logic [N-1:0] r;
    r = '0;
    if (tm) return {N{rstn}};
    for (int k = 0; k < N; k++) begin
      r[k] = (rel_start >= 0) && (e - rel_start >= SD * k)
             && !(e < pend[k]);
    end
    return r;
  endfunction

  function automatic logic exp_ready();
    if (tm) return rstn;
    return (rel_start >= 0) && (e - rel_start >= SD * (N - 1));
  endfunction

  task automatic model_edge();
    bit ls;
    e++;
    if (!rstn) begin
      sq = {};
      repeat (SS) sq.push_back(1'b0);
      run = 0;
      rel_start = -1;
      m_lost = 1'b0;
      for (int k = 0; k < N; k++) pend[k] = 0;
      return;
    end
    ls = sq.pop_front();
    sq.push_back(lock);
    if (rel_start >= 0) begin
      if (!ls) begin
        rel_start = -1;
        run = 0;
        m_lost = 1'b1;
        for (int k = 0; k < N; k++) pend[k] = 0;
      end else if ((e - 1) - rel_start >= SD * (N - 1)) begin
        for (int k = 0; k < N; k++) if (sw[k]) pend[k] = e + SP;
      end
    end else if (ls) begin
      run++;
      if (run == LF) begin
        rel_start = e;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    sw = '0;
    chk("rstn_o", rstn_o, exp_rstn());
    chk("ready_o", ready, exp_ready());
    chk("lock_lost_o", lost, m_lost);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
  endtask

  initial begin
    int lo0;
    int lo2;
    int seg;
    bit lv;
    checks = 0;
    fails = 0;
    e = 0;
    run = 0;
    rel_start = -1;
    m_lost = 1'b0;
    for (int k = 0; k < N; k++) pend[k] = 0;
    repeat (SS) sq.push_back(1'b0);
    rstn = 1'b0;
    lock = 1'b1;
    tm = 1'b0;
    sw = '0;
    sw1 = '0;

    repeat (3) step();
    chk("reset_rstn_o", rstn_o, 4'b0000);
    chk("reset_ready", ready, 1'b0);
    chk("reset_lost", lost, 1'b0);

    // Power-up with lock already high.
    rstn = 1'b1;
    for (int i = 0; i < 46; i++) begin
      step();
      if (i == 1)  chk("n1_ready_e1", ready1, 1'b0);
      if (i == 2)  chk("n1_ready_e2", ready1, 1'b1);
      if (i == 2)  chk("n1_rstn_e2", rstn1_o, 1'b1);
      if (i == 16) chk("seq_e16", rstn_o, 4'b0000);
      if (i == 17) chk("seq_e17", rstn_o, 4'b0001);
      if (i == 24) chk("seq_e24", rstn_o, 4'b0001);
      if (i == 25) chk("seq_e25", rstn_o, 4'b0011);
      if (i == 33) chk("seq_e33", rstn_o, 4'b0111);
      if (i == 40) chk("ready_e40", ready, 1'b0);
      if (i == 41) chk("seq_e41", rstn_o, 4'b1111);
      if (i == 41) chk("ready_e41", ready, 1'b1);
    end
    chk("no_lost", lost, 1'b0);

    // Software pulses on ch0/ch2, ch2 re-requested two edges later.
    lo0 = 0;
    lo2 = 0;
    sw = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!rstn_o[0]) lo0++;
      if (!rstn_o[2]) lo2++;
      if (i == 1) sw = 4'b0100;
    end
    chk("sw_ch0_len", lo0, 4);
    chk("sw_ch2_len", lo2, 6);
    chk("sw_ready", ready, 1'b1);

    for (int i = 0; i < 30; i++) begin
      sw = N'($urandom & $urandom & $urandom);
      step();
    end

    // Lock loss in RUN.
    repeat (6) step();
    lock = 1'b0;
    step();
    step();
    chk("loss_e2", rstn_o, 4'b1111);
    step();
    chk("loss_e3", rstn_o, 4'b0000);
    chk("loss_lost", lost, 1'b1);
    lock = 1'b1;

    // Lock drop during RELEASE then relock.
    do_reset();
    for (int i = 0; i < 70; i++) begin
      step();
      if (i == 29) lock = 1'b0;
      if (i == 35) lock = 1'b1;
      if (i == 31) chk("rel_drop_e31", rstn_o, 4'b0011);
      if (i == 31) chk("rel_lost_e31", lost, 1'b0);
      if (i == 32) chk("rel_drop_e32", rstn_o, 4'b0000);
      if (i == 32) chk("rel_lost_e32", lost, 1'b1);
      if (i == 52) chk("relock_e52", rstn_o, 4'b0000);
      if (i == 53) chk("relock_e53", rstn_o, 4'b0001);
    end

    // Chattering lock never qualifies.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      lock = 1'b1;
      repeat (10) step();
      lock = 1'b0;
      repeat (3) step();
    end
    chk("chatter_rstn", rstn_o, 4'b0000);
    lock = 1'b1;
    repeat (45) step();
    chk("chatter_ready", ready, 1'b1);

    // Reset mid-RELEASE and mid-pulse.
    do_reset();
    repeat (21) step();
    rstn = 1'b0;
    step();
    chk("rst_rel_rstn", rstn_o, 4'b0000);
    chk("rst_rel_ready", ready, 1'b0);
    rstn = 1'b1;
    repeat (45) step();
    sw = 4'b1111;
    step();
    step();
    rstn = 1'b0;
    step();
    chk("rst_pulse_rstn", rstn_o, 4'b0000);
    chk("rst_pulse_ready", ready, 1'b0);
    rstn = 1'b1;

    // Random lock, requests and occasional reset.
    seg = 0;
    lv = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (seg == 0) begin
        seg = $urandom_range(40, 1);
        lv = ($urandom_range(3, 0) != 0);
      end
      seg--;
      lock = lv;
      sw = N'($urandom & $urandom & $urandom);
      rstn = ($urandom_range(199, 0) != 0);
      step();
    end
    rstn = 1'b1;

    // Test mode: outputs follow rstn_i with no clock.
    tm = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rstn = ($urandom_range(3, 0) != 0);
      lock = 1'($urandom);
      #1;
      chk("tm_rstn", rstn_o, {N{rstn}});
      chk("tm_ready", ready, rstn);
      chk("tm_n1", rstn1_o, rstn);
      step();
    end
    tm = 1'b0;
    rstn = 1'b1;
    lock = 1'b1;
    repeat (60) step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
